divider_arbiter: RTL
====================

// Module: divider_arbiter
// PURPOSE
//  Shares one sequential restoring divider (start/ready, WIDTH+1 cycle latency) among N_REQ
//  requesters, e.g. per-channel depth/centroid normalisation in the scanner pipeline.
//  Round-robin grant, operand capture, start pulse, result return on valid/ready,
//  zero-divisor bypass and a hang watchdog.
// PARAMETERS
//  N_REQ    4          number of requesters (>=2); IDW = $clog2(N_REQ) (localparam)
//  WIDTH    8          operand/result width, must match attached divider
//  TIMEOUT  WIDTH+4    max cycles in WAIT before error abort
// PORTS
//  clk            in   1            system clock
//  rst_n          in   1            asynchronous active-low reset
//  req_valid      in   N_REQ        request pending, one bit per requester
//  req_ready      out  N_REQ        one-hot accept pulse; operands sampled this cycle
//  req_dividend   in   N_REQ*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
//  req_divisor    in   N_REQ*WIDTH  packed divisors, same packing
//  req_sign       in   N_REQ        1 = two's-complement operands, 0 = unsigned
//  rsp_valid      out  1            result available; held until rsp_ready
//  rsp_ready      in   1            consumer accepts result
//  rsp_id         out  IDW          index of requester owning the result
//  rsp_quotient   out  WIDTH        quotient
//  rsp_remainder  out  WIDTH        remainder
//  rsp_dbz        out  1            divisor was zero (bypassed)
//  rsp_err        out  1            watchdog expired; quotient/remainder are zero
//  busy           out  1            FSM not in IDLE
//  div_start      out  1            one-cycle start pulse to divider
//  div_sign       out  1            captured sign mode
//  div_dividend   out  WIDTH        captured dividend (registered, stable from ISSUE to IDLE)
//  div_divider    out  WIDTH        captured divisor (registered)
//  div_quotient   in   WIDTH        divider quotient
//  div_remainder  in   WIDTH        divider remainder
//  div_ready      in   1            divider one-cycle done pulse
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr pointer=N_REQ-1 (requester 0 wins first), watchdog=0.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: if any req_valid, grant = first set bit scanning from ptr+1 upward, wrapping mod N_REQ;
//   req_ready[grant]=1 for that single cycle; capture operands, sign, id; ptr<=grant.
//   Divisor==0 -> RESP with rsp_quotient={WIDTH{1'b1}}, rsp_remainder=dividend, rsp_dbz=1.
//   Else -> ISSUE. No req_valid -> stay, req_ready=0.
//  ISSUE: div_start=1 exactly one cycle; -> WAIT; watchdog cleared.
//  WAIT: div_ready sampled only here. On div_ready: latch div_quotient/div_remainder into
//   rsp_* registers, -> RESP. Watchdog increments each WAIT cycle; reaching TIMEOUT with no
//   div_ready -> RESP with rsp_err=1, quotient/remainder=0.
//  RESP: rsp_valid=1, rsp_* stable; on rsp_ready -> IDLE (rsp_valid low next cycle,
//   rsp_dbz/rsp_err cleared). Back-to-back: new grant earliest the cycle after return to IDLE.
//  div_ready in IDLE/ISSUE/RESP is ignored (divider has no reset; stale pulses after rst_n).
//  Request inputs need not be stable after the accept cycle; divider operands come from
//  capture registers only. req_valid dropped before accept: no grant, no side effects.
//  Nominal latency non-zero divisor: accept->rsp_valid = WIDTH+3 cycles (ISSUE, WIDTH+1 divider, latch).
//  Zero divisor: rsp_valid the cycle after accept.
//  rst_n asserted mid-operation: immediate return to reset state, pending result dropped,
//  no rsp_valid; next operation restarts divider via div_start.
//  Fairness: requester held valid is served within N_REQ grants.
// TESTING
//  Single req0 unsigned 100/7 -> req_ready[0] pulse, div_start 1 cycle later, rsp q=14 r=2 id=0 at +11.
//  Signed req2 -100/7 (0x9C/0x07) -> rsp q=0xF2 (-14) r=0xFE (-2) id=2, dbz=0, err=0.
//  All four valid continuously -> grant order 0,1,2,3,0; each rsp_id matches; no starvation.
//  req1 divisor 0, dividend 0x55 -> rsp next cycle q=0xFF r=0x55 dbz=1, div_start never pulses.
//  Divider model never pulses ready -> rsp_err=1 after TIMEOUT WAIT cycles, q=r=0, FSM back to IDLE.
//  rsp_ready held low 20 cycles then rst_n pulse -> rsp_valid drops immediately, ptr reset, next grant req0.

Source files
------------

// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one sequential divider among N_REQ requesters.
// Captures operands on accept, bypasses zero divisors and aborts a hung divider with an error response.
module divider_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = WIDTH + 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_dividend,
    input  logic [N_REQ*WIDTH-1:0]   req_divisor,
    input  logic [N_REQ-1:0]         req_sign,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_dbz,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     div_start,
    output logic                     div_sign,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divider,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    input  logic                     div_ready
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   ptr_q;
    logic [WDW-1:0]   wdog_q;

    logic [IDW-1:0]   grant_c;
    logic             any_c;
    logic             accept_c;
    logic             dbz_c;
    logic             expire_c;
    logic [WIDTH-1:0] sel_dividend_c;
    logic [WIDTH-1:0] sel_divisor_c;
    logic             sel_sign_c;

    // Index of the requester 'off' positions above 'base', wrapping mod N_REQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % N_REQ;
        return IDW'(sum);
    endfunction

    // Round-robin search starting just above the last winner.
    always_comb begin
        grant_c = ptr_q;
        any_c   = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            if (!any_c && req_valid[rr_idx(ptr_q, off)]) begin
                grant_c = rr_idx(ptr_q, off);
                any_c   = 1'b1;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_dividend_c = '0;
        sel_divisor_c  = '0;
        sel_sign_c     = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c == IDW'(i)) begin
                sel_dividend_c = req_dividend[i*WIDTH +: WIDTH];
                sel_divisor_c  = req_divisor[i*WIDTH +: WIDTH];
                sel_sign_c     = req_sign[i];
            end
        end
    end

    // Accept is same-cycle with the request, so req_ready cannot be registered;
    // it is held low while reset is asserted because nothing is captured then.
    always_comb begin
        accept_c  = rst_n && (state_q == IDLE) && any_c;
        dbz_c     = (sel_divisor_c == '0);
        expire_c  = (wdog_q == WDW'(TIMEOUT - 1));
        req_ready = accept_c ? (N_REQ'(1) << grant_c) : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = dbz_c ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (div_ready || expire_c) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            div_start <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            busy      <= (state_d != IDLE);
            div_start <= (state_d == ISSUE);
            rsp_valid <= (state_d == RESP);
        end
    end

    // Capture, result latch, watchdog and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= IDW'(N_REQ - 1);
            wdog_q        <= '0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b0;
            div_sign      <= 1'b0;
            div_dividend  <= '0;
            div_divider   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        ptr_q        <= grant_c;
                        rsp_id       <= grant_c;
                        div_sign     <= sel_sign_c;
                        div_dividend <= sel_dividend_c;
                        div_divider  <= sel_divisor_c;
                        rsp_err      <= 1'b0;
                        if (dbz_c) begin
                            rsp_quotient  <= '1;
                            rsp_remainder <= sel_dividend_c;
                            rsp_dbz       <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wdog_q <= '0;
                end
                WAIT: begin
                    if (div_ready) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                    end else if (expire_c) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_err       <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_dbz <= 1'b0;
                        rsp_err <= 1'b0;
                    end
                end
                default: begin
                    wdog_q <= '0;
                end
            endcase
        end
    end

endmodule
